pipe_hazard_scoreboard: RTL and testbench

//  Parametrised hazard-detection + forwarding controller for the 5-stage pipeline; replaces
//  the separate decode-stage hazard check and EX-stage forwarding unit. Tracks every in-flight

---
 rtl/pipe_hazard_scoreboard_pkg.sv | 31 +++
 rtl/pipe_hazard_scoreboard_if.sv | 34 +++
 rtl/pipe_hazard_scoreboard_sb_slot.sv | 47 ++++
 rtl/pipe_hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard: forwarding-mux encodings,
// slot-control opcodes and the forwarding priority helper.
package pipe_hazard_scoreboard_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_WB    = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    SLOT_LOAD   = 2'd0,
    SLOT_HOLD   = 2'd1,
    SLOT_BUBBLE = 2'd2
  } slot_op_e;

  // The younger producer (EX/MEM) wins over WB when both hold the register.
  function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_EXMEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode/pipeline-control bundle between the pipeline (master) and the
// hazard scoreboard (slave).
interface pipe_hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              fwd_en;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_use_src2;
  logic [REG_AW-1:0] id_dst;
  logic              id_wr_en;
  logic              id_is_load;
  logic              flush;
  logic              mem_stall;
  logic              stall;
  logic              ex_hold;
  logic [1:0]        ex_fwd_sel1;
  logic [1:0]        ex_fwd_sel2;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_use_src2, id_dst,
           id_wr_en, id_is_load, flush, mem_stall,
    input  stall, ex_hold, ex_fwd_sel1, ex_fwd_sel2, stall_count
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_use_src2, id_dst,
           id_wr_en, id_is_load, flush, mem_stall,
    output stall, ex_hold, ex_fwd_sel1, ex_fwd_sel2, stall_count
  );
endinterface

// File: rtl/pipe_hazard_scoreboard_sb_slot.sv
// One tracked pipeline slot: a valid bit plus an opaque payload that can be
// loaded, held, or replaced by a bubble.
module sb_slot
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  slot_op_e     op_i,
  input  logic         v_i,
  input  logic [W-1:0] data_i,
  output logic         v_o,
  output logic [W-1:0] data_o
);

  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;

  // A bubble only clears valid; the stale payload is masked by v.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    unique case (op_i)
      SLOT_LOAD: begin
        v_d    = v_i;
        data_d = data_i;
      end
      SLOT_BUBBLE: v_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard detection and EX forwarding control for the 5-stage pipeline: tracks
// writers in EX/MEM/WB, raises the decode stall and drives the bypass selects.
module pipe_hazard_scoreboard
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW  = 3,
  parameter bit          HARD_R0 = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input logic                     clk,
  input logic                     rst,
  pipe_hazard_scoreboard_if.slave bus
);

  localparam int unsigned EX_W  = 3 * REG_AW + 3;
  localparam int unsigned MEM_W = REG_AW + 2;
  localparam int unsigned WB_W  = REG_AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_op_e          ex_op, mem_op, wb_op;
  logic              ex_v_in;
  logic              ex_v, mem_v, wb_v;
  logic [EX_W-1:0]   ex_data;
  logic [MEM_W-1:0]  mem_data;
  logic [WB_W-1:0]   wb_data;
  logic              ex_wr, ex_ld, ex_u2, mem_wr, mem_ld, wb_wr;
  logic [REG_AW-1:0] ex_dst, ex_s1, ex_s2, mem_dst, wb_dst;
  logic              id_ex_hit, id_mem_hit, hz_stall;
  fwd_sel_e          sel1, sel2;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  function automatic logic hit(input logic v, input logic wr,
                               input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] r);
    return v & wr & (dst == r) & ~(HARD_R0 & (r == '0));
  endfunction

  assign {ex_wr, ex_ld, ex_dst, ex_s1, ex_s2, ex_u2} = ex_data;
  assign {mem_wr, mem_ld, mem_dst}                   = mem_data;
  assign {wb_wr, wb_dst}                             = wb_data;

  sb_slot #(.W(EX_W)) u_ex (
    .clk    (clk),
    .rst    (rst),
    .op_i   (ex_op),
    .v_i    (ex_v_in),
    .data_i ({bus.id_wr_en, bus.id_is_load, bus.id_dst, bus.id_src1,
              bus.id_src2, bus.id_use_src2}),
    .v_o    (ex_v),
    .data_o (ex_data)
  );

  sb_slot #(.W(MEM_W)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .op_i   (mem_op),
    .v_i    (ex_v),
    .data_i (ex_data[EX_W-1 -: MEM_W]),
    .v_o    (mem_v),
    .data_o (mem_data)
  );

  sb_slot #(.W(WB_W)) u_wb (
    .clk    (clk),
    .rst    (rst),
    .op_i   (wb_op),
    .v_i    (mem_v),
    .data_i ({mem_wr, mem_dst}),
    .v_o    (wb_v),
    .data_o (wb_data)
  );

  // WB writers never stall: the register file writes before decode reads.
  always_comb begin
    id_ex_hit  = hit(ex_v, ex_wr, ex_dst, bus.id_src1)
               | (bus.id_use_src2 & hit(ex_v, ex_wr, ex_dst, bus.id_src2));
    id_mem_hit = hit(mem_v, mem_wr, mem_dst, bus.id_src1)
               | (bus.id_use_src2 & hit(mem_v, mem_wr, mem_dst, bus.id_src2));
    hz_stall   = 1'b0;
    if (bus.id_valid) begin
      hz_stall = bus.fwd_en ? (id_ex_hit & ex_ld) : (id_ex_hit | id_mem_hit);
    end
  end

  // Memory stall freezes EX and injects a bubble into MEM while WB drains.
  always_comb begin
    ex_op   = SLOT_LOAD;
    mem_op  = SLOT_LOAD;
    wb_op   = SLOT_LOAD;
    ex_v_in = bus.id_valid & ~hz_stall & ~bus.flush;
    if (bus.mem_stall) begin
      ex_op  = SLOT_HOLD;
      mem_op = SLOT_BUBBLE;
    end
  end

  always_comb begin
    sel1 = FWD_RF;
    sel2 = FWD_RF;
    if (bus.fwd_en) begin
      sel1 = fwd_pick(hit(mem_v, mem_wr, mem_dst, ex_s1) & ~mem_ld,
                      hit(wb_v, wb_wr, wb_dst, ex_s1));
      if (ex_u2) begin
        sel2 = fwd_pick(hit(mem_v, mem_wr, mem_dst, ex_s2) & ~mem_ld,
                        hit(wb_v, wb_wr, wb_dst, ex_s2));
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hz_stall && !bus.mem_stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall       = hz_stall | bus.mem_stall;
  assign bus.ex_hold     = bus.mem_stall;
  assign bus.ex_fwd_sel1 = 2'(sel1);
  assign bus.ex_fwd_sel2 = 2'(sel2);
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard_if #(.REG_AW(3), .CNT_W(16)) ifa ();
  pipe_hazard_scoreboard_if #(.REG_AW(3), .CNT_W(2))  ifb ();

  pipe_hazard_scoreboard #(.REG_AW(3), .HARD_R0(1'b0), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa)
  );
  pipe_hazard_scoreboard #(.REG_AW(3), .HARD_R0(1'b1), .CNT_W(2)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb)
  );

  typedef struct {
    string nm;
    int    dut;
    logic  stall;
    logic  hold;
    int    s1;
    int    s2;
    int    cnt;
    bit    chk_sel;
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic a_st, a_hd;
    int   a_s1, a_s2, a_cnt;
    bit   bad;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.dut == 0) begin
        a_st = ifa.stall; a_hd = ifa.ex_hold;
        a_s1 = int'(ifa.ex_fwd_sel1); a_s2 = int'(ifa.ex_fwd_sel2);
        a_cnt = int'(ifa.stall_count);
      end else begin
        a_st = ifb.stall; a_hd = ifb.ex_hold;
        a_s1 = int'(ifb.ex_fwd_sel1); a_s2 = int'(ifb.ex_fwd_sel2);
        a_cnt = int'(ifb.stall_count);
      end
      bad = (a_st !== e.stall) || (a_hd !== e.hold) || (a_cnt != e.cnt);
      if (e.chk_sel && ((a_s1 != e.s1) || (a_s2 != e.s2))) bad = 1'b1;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got stall=%0b hold=%0b sel1=%0d sel2=%0d cnt=%0d, want stall=%0b hold=%0b sel1=%0d sel2=%0d cnt=%0d (sel checked=%0b)",
                 e.nm, a_st, a_hd, a_s1, a_s2, a_cnt,
                 e.stall, e.hold, e.s1, e.s2, e.cnt, e.chk_sel);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input int d, input logic v, input int s1, input int s2,
                     input logic u2, input int dst, input logic wr, input logic ld);
    if (d == 0) begin
      ifa.id_valid = v; ifa.id_src1 = 3'(s1); ifa.id_src2 = 3'(s2);
      ifa.id_use_src2 = u2; ifa.id_dst = 3'(dst); ifa.id_wr_en = wr; ifa.id_is_load = ld;
    end else begin
      ifb.id_valid = v; ifb.id_src1 = 3'(s1); ifb.id_src2 = 3'(s2);
      ifb.id_use_src2 = u2; ifb.id_dst = 3'(dst); ifb.id_wr_en = wr; ifb.id_is_load = ld;
    end
  endtask

  task automatic idle(input int d);
    dec(d, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input int d, input logic fwd, input logic fl, input logic ms);
    if (d == 0) begin
      ifa.fwd_en = fwd; ifa.flush = fl; ifa.mem_stall = ms;
    end else begin
      ifb.fwd_en = fwd; ifb.flush = fl; ifb.mem_stall = ms;
    end
  endtask

  task automatic expv(input string nm, input int d, input logic st, input logic hd,
                      input int s1, input int s2, input int cnt, input bit cs);
    exp_t e;
    e.nm = nm; e.dut = d; e.stall = st; e.hold = hd;
    e.s1 = s1; e.s2 = s2; e.cnt = cnt; e.chk_sel = cs;
    expq.push_back(e);
  endtask

  task automatic do_reset(input int d);
    if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    idle(d);
    ctl(d, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    idle(0); idle(1);
    ctl(0, 1'b1, 1'b0, 1'b0); ctl(1, 1'b1, 1'b0, 1'b0);
    tick();
    expv("reset_a", 0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    expv("reset_b", 1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // ALU producer forwarded from EX/MEM with no stall
    dec(0, 1, 2, 3, 1, 1, 1, 0); expv("t1_add", 0, 0, 0, 0, 0, 0, 1'b0); tick();
    dec(0, 1, 1, 3, 1, 2, 1, 0); expv("t1_sub_id", 0, 0, 0, 0, 0, 0, 1'b1); tick();
    idle(0); expv("t1_sub_ex", 0, 0, 0, 1, 0, 0, 1'b1); tick();
    do_reset(0);

    // load-use: one bubble then WB forward on both operands
    dec(0, 1, 5, 0, 0, 4, 1, 1); tick();
    dec(0, 1, 4, 4, 1, 5, 1, 0); expv("t2_loaduse", 0, 1, 0, 0, 0, 0, 1'b1); tick();
    expv("t2_bubble", 0, 0, 0, 0, 0, 1, 1'b0); tick();
    idle(0); expv("t2_fwd_wb", 0, 0, 0, 2, 2, 1, 1'b1); tick();
    do_reset(0);

    // stall-only mode: two bubbles for an EX producer
    ctl(0, 0, 0, 0);
    dec(0, 1, 2, 3, 1, 1, 1, 0); tick();
    dec(0, 1, 1, 3, 1, 2, 1, 0); expv("t3_stall1", 0, 1, 0, 0, 0, 0, 1'b1); tick();
    expv("t3_stall2", 0, 1, 0, 0, 0, 1, 1'b1); tick();
    expv("t3_release", 0, 0, 0, 0, 0, 2, 1'b1); tick();
    idle(0); expv("t3_ex", 0, 0, 0, 0, 0, 2, 1'b1); tick();
    do_reset(0);

    // memory stall with producer in MEM and consumer held in EX
    dec(0, 1, 1, 2, 1, 6, 1, 0); tick();
    dec(0, 1, 6, 3, 1, 7, 1, 0); tick();
    idle(0); ctl(0, 1, 0, 1);
    expv("t4_ms1", 0, 1, 1, 1, 0, 0, 1'b1); tick();
    expv("t4_ms2", 0, 1, 1, 2, 0, 0, 1'b1); tick();
    expv("t4_ms3", 0, 1, 1, 0, 0, 0, 1'b0); tick();
    ctl(0, 1, 0, 0); expv("t4_release", 0, 0, 0, 0, 0, 0, 1'b0); tick();
    do_reset(0);

    // hazard coinciding with a memory stall is not counted
    ctl(0, 0, 0, 0);
    dec(0, 1, 2, 3, 1, 1, 1, 0); tick();
    dec(0, 1, 1, 0, 0, 2, 1, 0); ctl(0, 0, 0, 1);
    expv("t4b_ms_hz", 0, 1, 1, 0, 0, 0, 1'b1); tick();
    ctl(0, 0, 0, 0); expv("t4b_hz", 0, 1, 0, 0, 0, 0, 1'b1); tick();
    expv("t4b_cnt", 0, 1, 0, 0, 0, 1, 1'b1); tick();
    do_reset(0);

    // flush wins over a pending load-use and kills the decode instruction
    dec(0, 1, 5, 0, 0, 4, 1, 1); tick();
    dec(0, 1, 4, 0, 0, 5, 1, 0); ctl(0, 1, 1, 0);
    expv("t5_flush_hz", 0, 1, 0, 0, 0, 0, 1'b1); tick();
    dec(0, 1, 1, 2, 1, 5, 1, 0);
    expv("t5_flush_only", 0, 0, 0, 0, 0, 1, 1'b0); tick();
    dec(0, 1, 5, 0, 0, 6, 1, 0); ctl(0, 1, 0, 0);
    expv("t5_after", 0, 0, 0, 0, 0, 1, 1'b0); tick();
    idle(0); expv("t5_killed", 0, 0, 0, 0, 0, 1, 1'b1); tick();
    do_reset(0);

    // reset with all three slots occupied drops all tracking
    dec(0, 1, 5, 6, 1, 1, 1, 0); tick();
    dec(0, 1, 3, 4, 1, 2, 1, 0); tick();
    dec(0, 1, 1, 2, 1, 3, 1, 0); tick();
    dec(0, 1, 5, 6, 1, 4, 1, 0); expv("t6_pre", 0, 0, 0, 2, 1, 0, 1'b1); tick();
    rst_a = 1'b1; ctl(0, 0, 0, 0); dec(0, 1, 4, 0, 0, 7, 1, 0); tick();
    rst_a = 1'b0; expv("t6_post", 0, 0, 0, 0, 0, 0, 1'b1); tick();
    idle(0);

    // constant register 0 never matches
    ctl(1, 0, 0, 0);
    dec(1, 1, 1, 0, 0, 0, 1, 0); tick();
    dec(1, 1, 0, 0, 1, 3, 1, 0); expv("r0_nostall", 1, 0, 0, 0, 0, 0, 1'b1); tick();
    idle(1); ctl(1, 1, 0, 0); expv("r0_nofwd", 1, 0, 0, 0, 0, 0, 1'b1); tick();
    do_reset(1);

    // 2-bit counter saturates at 3 across a chain of dependencies
    ctl(1, 0, 0, 0);
    dec(1, 1, 2, 3, 1, 1, 1, 0); tick();
    dec(1, 1, 1, 0, 0, 2, 1, 0);
    expv("sat_c1", 1, 1, 0, 0, 0, 0, 1'b1); tick();
    expv("sat_c2", 1, 1, 0, 0, 0, 1, 1'b1); tick();
    expv("sat_c3", 1, 0, 0, 0, 0, 2, 1'b1); tick();
    dec(1, 1, 2, 0, 0, 3, 1, 0);
    expv("sat_c4", 1, 1, 0, 0, 0, 2, 1'b1); tick();
    expv("sat_c5", 1, 1, 0, 0, 0, 3, 1'b1); tick();
    expv("sat_c6", 1, 0, 0, 0, 0, 3, 1'b1); tick();
    dec(1, 1, 3, 0, 0, 4, 1, 0);
    expv("sat_c7", 1, 1, 0, 0, 0, 3, 1'b1); tick();
    expv("sat_c8", 1, 1, 0, 0, 0, 3, 1'b1); tick();
    expv("sat_c9", 1, 0, 0, 0, 0, 3, 1'b1); tick();
    idle(1);
    tick();
    tick();

    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
